// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the synchronous FIFO and its storage array.
package sync_fifo_pkg;

    // Default data word width.
    localparam int DEF_DW = 8;

    // Default depth in words (power of two, at least 2).
    localparam int DEF_W  = 16;

    // Default almost_empty threshold (count <= AE).
    localparam int DEF_AE = 1;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo: synchronous write, combinational read, no reset.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int dw = DEF_DW,
    parameter int w  = DEF_W,
    localparam int aw = $clog2(w)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [aw-1:0] waddr,
    input  logic [dw-1:0] wdata,
    input  logic [aw-1:0] raddr,
    output logic [dw-1:0] rdata
);

    logic [dw-1:0] mem [w];

    // Write port: one word per clock when enabled.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is asynchronous so the head word falls through.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with ready/valid on both sides,
// occupancy count, almost_full/almost_empty watermarks and flush.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int dw = DEF_DW,
    parameter int w  = DEF_W,
    parameter int AF = w - 2,
    parameter int AE = DEF_AE,
    localparam int aw = $clog2(w)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [dw-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [dw-1:0] out_data,
    output logic [aw:0]   count,
    output logic          almost_full,
    output logic          almost_empty
);

    // Pointers carry one extra wrap bit to tell full from empty.
    localparam int pw = aw + 1;
    localparam logic [pw-1:0] ptr_one = {{aw{1'b0}}, 1'b1};
    localparam logic [pw-1:0] af_lvl  = AF[pw-1:0];
    localparam logic [pw-1:0] ae_lvl  = AE[pw-1:0];

    logic [pw-1:0] wr_ptr;
    logic [pw-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          mem_we;
    logic [dw-1:0] rdata;

    // Flags and handshakes depend only on registered pointers, so there is
    // no combinational path from in_valid/out_ready to in_ready/out_valid.
    always_comb begin
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);
        in_ready     = !full;
        out_valid    = !empty;
        push         = in_valid && !full;
        pop          = out_ready && !empty;
        mem_we       = push && !flush && !reset;
        count        = wr_ptr - rd_ptr;
        almost_full  = (count >= af_lvl);
        almost_empty = (count <= ae_lvl);
        out_data     = empty ? '0 : rdata;
    end

    // Pointer update: reset beats flush, flush discards any push/pop this cycle.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_one;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_one;
            end
        end
    end

    fifo_mem #(
        .dw (dw),
        .w  (w)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (wr_ptr[aw-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[aw-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (dw=8, w=4): directed scenarios plus a
// long randomized run against a queue-based reference model.
module tb_sync_fifo;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int AW = 2;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          almost_full;
    logic          almost_empty;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [$];

    sync_fifo #(
        .dw (DW),
        .w  (W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock edge; the reference queue follows the FIFO rules for the
    // inputs currently driven. Returns 1 ns after the edge.
    task automatic tick();
        bit do_push;
        bit do_pop;
        do_push = in_valid && (mq.size() < W);
        do_pop  = out_ready && (mq.size() > 0);
        @(posedge clock);
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(in_data);
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %b want 1", almost_empty); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b want 0", almost_full); end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            tick();
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count got %0d want %0d", count, i + 1); end
            checks++; if (almost_full !== (i + 1 >= 2)) begin errors++; $display("FAIL fill_almost_full got %b want %b at count %0d", almost_full, (i + 1 >= 2), i + 1); end
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== words[i]) begin errors++; $display("FAIL drain_data got v=%b %h want v=1 %h", out_valid, out_data, words[i]); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] exp_out [4];
        exp_out[0] = 8'h22; exp_out[1] = 8'h33; exp_out[2] = 8'h44; exp_out[3] = 8'h55;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'((i + 1) * 8'h11);
            tick();
        end
        in_data   = 8'h55;
        out_ready = 1'b1;
        tick();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d want 3", count); end
        out_ready = 1'b0;
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_repush_count got %0d want 4", count); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_data !== exp_out[i]) begin errors++; $display("FAIL full_pop_order got %h want %h", out_data, exp_out[i]); end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stream_wrap();
        idle_inputs();
        for (int k = 0; k <= 20; k++) begin
            in_valid  = (k < 20);
            in_data   = 8'(k);
            out_ready = (k >= 1);
            if (k >= 1) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 8'(k - 1)) begin errors++; $display("FAIL stream_data got v=%b %h want v=1 %h", out_valid, out_data, 8'(k - 1)); end
            end
            checks++; if (count > 3'd2) begin errors++; $display("FAIL stream_count got %0d want <=2", count); end
            tick();
        end
        idle_inputs();
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL stream_end got v=%b count=%0d want v=0 count=0", out_valid, count); end
    endtask

    task automatic test_flush();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA1 + i);
            tick();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d want 3", count); end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
        tick();
        idle_inputs();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL flush_out got v=%b %h want v=0 00", out_valid, out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        in_valid = 1'b1; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        checks++; if (out_data !== 8'h77 || count !== 3'd1) begin errors++; $display("FAIL flush_after got %h count=%0d want 77 count=1", out_data, count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stale got v=%b %h want v=0", out_valid, out_data); end
    endtask

    task automatic test_random();
        int n;
        logic [DW-1:0] exp_data;
        idle_inputs();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            in_data   = 8'($urandom_range(0, 255));
            n = mq.size();
            exp_data = (n > 0) ? mq[0] : 8'h00;
            checks++;
            if (count !== 3'(n) || out_valid !== (n > 0) || in_ready !== (n < W) ||
                out_data !== exp_data || almost_full !== (n >= W - 2) || almost_empty !== (n <= 1)) begin
                errors++;
                $display("FAIL random_cycle %0d got count=%0d v=%b r=%b d=%h af=%b ae=%b want count=%0d v=%b r=%b d=%h af=%b ae=%b",
                         c, count, out_valid, in_ready, out_data, almost_full, almost_empty,
                         n, (n > 0), (n < W), exp_data, (n >= W - 2), (n <= 1));
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_full_pop();
        test_stream_wrap();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parameterised synchronous FIFO with ready/valid handshakes on both sides, built from a write-synchronous storage array plus wrap-bit read/write pointers. It is the buffering element between the tape/control datapath and slower producers or consumers: a Memory_synth-class array that adds occupancy tracking, flow control, watermarks and flush. Output is first-word-fall-through: the head entry is visible whenever the FIFO is non-empty.

## Interface
- dw, 8, data word width (≥1)
- w, 16, depth in words; power of two, ≥2
- aw, $clog2(w), pointer index width (derived, not overridden)
- AF, w-2, almost_full threshold: asserted when count ≥ AF (1..w)
- AE, 1, almost_empty threshold: asserted when count ≤ AE (0..w-1)

- clock  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high; one clock with reset=1 fully initialises
- flush  in  1  synchronous discard of all contents
- in_valid  in  1  producer has a word
- in_ready  out  1  FIFO accepts a word this cycle
- in_data  in  dw  write data
- out_valid  out  1  head word valid
- out_ready  in  1  consumer takes head word this cycle
- out_data  out  dw  head word
- count  out  aw+1  current occupancy, 0..w
- almost_full  out  1  count ≥ AF
- almost_empty  out  1  count ≤ AE

## Operation
- Pointers wr_ptr, rd_ptr: aw+1 bits; low aw bits index storage, MSB is the wrap bit. Both increment modulo 2^(aw+1).
- empty = (wr_ptr == rd_ptr); full = (index equal, wrap bits differ). count = wr_ptr − rd_ptr, aw+1 bits, unsigned.
- in_ready = !full; out_valid = !empty. Both are purely registered-state functions; no combinational path from in_valid/out_ready to either.
- push = in_valid & in_ready: storage[wr_ptr index] ← in_data, wr_ptr+1.
- pop = out_valid & out_ready: rd_ptr+1.
- out_data = storage[rd_ptr index] when out_valid, else all zeros.
- Push and pop in the same cycle: both occur, count unchanged.
- Full: in_ready=0, a push is impossible even if a pop occurs in the same cycle (no pass-through).
- Empty: out_valid=0, a pop is impossible. A word pushed into an empty FIFO does not bypass to out_data in the same cycle.
- flush=1: wr_ptr and rd_ptr ← 0. Any push or pop in that cycle is ignored. Storage contents are not cleared.
- Priority: reset > flush > push/pop.
- Storage is not reset. Out-of-reset observable behaviour depends only on the pointers.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, count=0, almost_full=0 (AF≥1), almost_empty=1.
- Write-to-read latency: a word pushed at edge N is on out_data with out_valid=1 after edge N (visible in cycle N+1).
- Pop takes effect at the edge. The next head, or out_valid=0, is visible the following cycle.
- count, almost_full and almost_empty update on the same edge as the push, pop or flush that changes them.
- Sustained throughput: 1 push + 1 pop per cycle when neither full nor empty.
- Reset or flush asserted mid-stream: after that edge the FIFO is empty and in_ready=1. Previously stored words are never presented again.
- Pointer wrap: after 2^(aw+1) pushes, wr_ptr returns to 0. full/empty remain correct across the wrap.

## Structure
- sync_fifo_pkg: no typedefs needed beyond localparams. Keep pointer width aw+1 as a localparam inside the module.
- One sub-module, fifo_mem: dw × w array, synchronous write (we, waddr, wdata), combinational read (raddr → rdata), no reset.
- The top level holds pointers, flags, the handshake and the out_data zero-gating.

## Test plan
- Reset: dw=8, w=4. Hold reset 1 cycle → in_ready=1, out_valid=0, out_data=0, count=0, almost_empty=1, almost_full=0.
- Fill/drain: push 0x11,0x22,0x33,0x44 with out_ready=0 → count=4, in_ready=0, almost_full=1 from count=2. Then out_ready=1 → out_data 0x11,0x22,0x33,0x44 on consecutive cycles, then out_valid=0.
- Full with simultaneous pop: with the FIFO full, drive in_valid=1, in_data=0x55, out_ready=1 → one pop, no push, count=3. Next cycle push succeeds → count=4, 0x55 is last out.
- Streaming wrap: push/pop every cycle for 20 words 0x00..0x13 with occupancy 1–2 → output order exact, count never exceeds 2, pointer wrap is exercised.
- Flush: with count=3, assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0. The flushed and in-flight words never appear.
- Random: 10k cycles of random in_valid/out_ready/flush against a scoreboard queue → data order, count and the watermarks always match.
